// File: rtl/minority_voter_pkg.sv
// Shared types and helpers for the minority/majority vote detector.
//   vote_mode_t : per-sample decision mode (minority or majority)
//   STATS_W     : width of the optional non-unanimous sample counter
//   vote_raw()  : unfiltered vote decision from a population count
package minority_voter_pkg;

    typedef enum logic {
        MODE_MINORITY = 1'b0,
        MODE_MAJORITY = 1'b1
    } vote_mode_t;

    localparam int unsigned STATS_W = 16;

    // Minority: at most half the inputs are set. Majority: more than half are set.
    function automatic logic vote_raw(input int unsigned pop, input vote_mode_t mode,
                                      input int unsigned n);
        if (mode == MODE_MAJORITY) begin
            return pop > (n / 2);
        end
        return pop <= (n / 2);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of an N-bit vote vector.
// Ports:
//   bits : N vote inputs
//   pop  : number of ones in bits, $clog2(N+1) bits wide
module vote_popcount #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]             bits,
    output logic [$clog2(N+1)-1:0]   pop
);

    localparam int unsigned PW = $clog2(N + 1);

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/minority_voter.sv
// Two-stage pipelined N-input vote detector with a persistence filter.
// Stage 1 registers the population count and mode of each valid sample; stage 2 forms
// the raw minority/majority decision and only lets f follow it after HOLD consecutive
// disagreeing samples. A mode change resyncs f to the raw decision immediately.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   in_valid     : in_bits/mode are sampled when high
//   in_bits      : N vote inputs
//   mode         : 0 = minority, 1 = majority
//   f            : filtered vote
//   f_valid      : one-cycle pulse per processed sample (two cycles after in_valid)
//   f_changed    : one-cycle pulse with f_valid when f toggled
//   disagree_cnt : saturating count of non-unanimous samples
//                  (present only when MINORITY_VOTER_STATS_EN is defined)
module minority_voter
    import minority_voter_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [N-1:0]        in_bits,
    input  logic                mode,
    output logic                f,
    output logic                f_valid,
    output logic                f_changed
`ifdef MINORITY_VOTER_STATS_EN
    ,
    output logic [STATS_W-1:0]  disagree_cnt
`endif
);

    localparam int unsigned PW = $clog2(N + 1);
    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    if ((N < 3) || (N > 15) || ((N % 2) == 0)) begin : g_bad_n
        $error("minority_voter: N must be odd and within 3..15");
    end
    if ((HOLD < 1) || (HOLD > 255)) begin : g_bad_hold
        $error("minority_voter: HOLD must be within 1..255");
    end

    // ---------------------------------------------------------------- stage 1
    logic [PW-1:0] pop;
    logic [PW-1:0] pop_q;
    vote_mode_t    mode_q;
    logic          v1_q;

    vote_popcount #(
        .N (N)
    ) u_popcount (
        .bits (in_bits),
        .pop  (pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            pop_q  <= '0;
            mode_q <= MODE_MINORITY;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                pop_q  <= pop;
                mode_q <= vote_mode_t'(mode);
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic          raw;
    logic          f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;
    vote_mode_t    last_mode_q, last_mode_d;
    logic          changed_d;
    logic          f_valid_q;
    logic          f_changed_q;

    always_comb begin
        raw = vote_raw({{(32 - PW){1'b0}}, pop_q}, mode_q, N);
    end

    always_comb begin
        f_d         = f_q;
        cnt_d       = cnt_q;
        last_mode_d = last_mode_q;
        changed_d   = 1'b0;
        // Idle cycles leave the filter untouched: it counts samples, not cycles.
        if (v1_q) begin
            if (mode_q != last_mode_q) begin
                // Resync without filtering; takes precedence over a pending toggle.
                f_d         = raw;
                cnt_d       = '0;
                changed_d   = (raw != f_q);
                last_mode_d = mode_q;
            end else if (raw == f_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(HOLD - 1)) begin
                f_d       = raw;
                cnt_d     = '0;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q         <= 1'b0;
            cnt_q       <= '0;
            last_mode_q <= MODE_MINORITY;
            f_valid_q   <= 1'b0;
            f_changed_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            cnt_q       <= cnt_d;
            last_mode_q <= last_mode_d;
            f_valid_q   <= v1_q;
            f_changed_q <= changed_d;
        end
    end

    assign f         = f_q;
    assign f_valid   = f_valid_q;
    assign f_changed = f_changed_q;

`ifdef MINORITY_VOTER_STATS_EN
    logic [STATS_W-1:0] stats_q;
    logic               unanimous;

    always_comb begin
        unanimous = (pop_q == '0) || (pop_q == PW'(N));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stats_q <= '0;
        end else if (v1_q && !unanimous && (stats_q != '1)) begin
            stats_q <= stats_q + STATS_W'(1);
        end
    end

    assign disagree_cnt = stats_q;
`endif

endmodule

// File: tb/tb_minority_voter.sv
// Bench for minority_voter: three instances (N=3/HOLD=1, N=5/HOLD=4, N=3/HOLD=8) driven
// with directed vectors, checked every cycle against a sample-level model plus literal
// expectations for the recorded f/f_changed sequences.
module tb_minority_voter;

    logic             clk;
    logic             rst;
    logic [2:0]       vld;
    logic [2:0][4:0]  bits;
    logic [2:0]       md;
    logic [2:0]       fo, fvo, fco;
    logic [2:0][15:0] dco;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        v;
        logic        f;
        logic        c;
        logic [15:0] s;
    } out_t;

    out_t pend [3];
    out_t expo [3];
    logic m_f [3];
    int   m_streak [3];
    logic m_last [3];
    int   m_stats [3];

    logic [31:0] hist_f [3];
    logic [31:0] hist_c [3];
    int          hist_n [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    minority_voter #(.N(3), .HOLD(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_bits(bits[0][2:0]), .mode(md[0]),
        .f(fo[0]), .f_valid(fvo[0]), .f_changed(fco[0])
`ifdef MINORITY_VOTER_STATS_EN
        , .disagree_cnt(dco[0])
`endif
    );

    minority_voter #(.N(5), .HOLD(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_bits(bits[1][4:0]), .mode(md[1]),
        .f(fo[1]), .f_valid(fvo[1]), .f_changed(fco[1])
`ifdef MINORITY_VOTER_STATS_EN
        , .disagree_cnt(dco[1])
`endif
    );

    minority_voter #(.N(3), .HOLD(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_bits(bits[2][2:0]), .mode(md[2]),
        .f(fo[2]), .f_valid(fvo[2]), .f_changed(fco[2])
`ifdef MINORITY_VOTER_STATS_EN
        , .disagree_cnt(dco[2])
`endif
    );

`ifndef MINORITY_VOTER_STATS_EN
    assign dco = '0;
`endif

    function automatic int n_of(input int i);
        return (i == 1) ? 5 : 3;
    endfunction

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0h, required %0h", name, inst, $time, act, req);
        end
    endtask

    // Sample-level model: per accepted sample, decide the vote from the ones count and
    // track how many disagreeing samples in a row have been seen.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    m_f[i] = 1'b0; m_streak[i] = 0; m_last[i] = 1'b0; m_stats[i] = 0;
                    pend[i] = '0;  expo[i] = '0;
                end else begin
                    expo[i] = pend[i];
                    if (vld[i]) begin
                        int   pop;
                        logic raw;
                        logic chg;
                        pop = 0;
                        for (int b = 0; b < n_of(i); b++) pop += int'(bits[i][b]);
                        raw = md[i] ? (pop > n_of(i) / 2) : (pop <= n_of(i) / 2);
                        chg = 1'b0;
                        if (md[i] != m_last[i]) begin
                            chg = (raw != m_f[i]);
                            m_f[i] = raw; m_streak[i] = 0; m_last[i] = md[i];
                        end else if (raw == m_f[i]) begin
                            m_streak[i] = 0;
                        end else begin
                            m_streak[i]++;
                            if (m_streak[i] == hold_of(i)) begin
                                m_f[i] = raw; m_streak[i] = 0; chg = 1'b1;
                            end
                        end
                        if (pop != 0 && pop != n_of(i) && m_stats[i] < 65535) m_stats[i]++;
                        pend[i] = '{v: 1'b1, f: m_f[i], c: chg, s: 16'(m_stats[i])};
                    end else begin
                        pend[i] = '{v: 1'b0, f: m_f[i], c: 1'b0, s: 16'(m_stats[i])};
                    end
                end
            end
        end
    end

    // Every-cycle compare against the model, plus a record of f/f_changed per f_valid.
    initial begin
        for (int i = 0; i < 3; i++) begin
            hist_f[i] = '0; hist_c[i] = '0; hist_n[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("f_valid", i, 32'(fvo[i]), 32'(expo[i].v));
                chk("f", i, 32'(fo[i]), 32'(expo[i].f));
                chk("f_changed", i, 32'(fco[i]), 32'(expo[i].c));
`ifdef MINORITY_VOTER_STATS_EN
                chk("disagree_cnt", i, 32'(dco[i]), 32'(expo[i].s));
`endif
                if (fvo[i] === 1'b1 && hist_n[i] < 32) begin
                    hist_f[i][hist_n[i]] = fo[i];
                    hist_c[i][hist_n[i]] = fco[i];
                    hist_n[i]++;
                end
            end
        end
    end

    task automatic send(input int i, input logic [4:0] b, input logic m);
        @(negedge clk);
        vld    = '0;
        vld[i] = 1'b1;
        bits[i] = b;
        md[i]   = m;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vld = '0;
        end
    endtask

    initial begin
        int n_before;
        rst = 1'b1; vld = '0; bits = '0; md = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_f", 0, 32'(fo), 32'h0);
        chk("reset_f_valid", 0, 32'(fvo), 32'h0);
        chk("reset_f_changed", 0, 32'(fco), 32'h0);

        // N=3, HOLD=1, minority: f follows raw for every input pattern.
        for (int v = 0; v < 8; v++) send(0, 5'(v), 1'b0);
        idle(4);
        chk("seq8_count", 0, 32'(hist_n[0]), 32'd8);
        chk("seq8_f", 0, 32'(hist_f[0][7:0]), 32'b0001_0111);
        chk("seq8_changed", 0, 32'(hist_c[0][7:0]), 32'b0011_1001);

        // Statistics over 000, 001, 111, 110.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        send(0, 5'b000, 1'b0);
        send(0, 5'b001, 1'b0);
        send(0, 5'b111, 1'b0);
        send(0, 5'b110, 1'b0);
        idle(3);
`ifdef MINORITY_VOTER_STATS_EN
        chk("stats_lit", 0, 32'(dco[0]), 32'd2);
`endif
        send(0, 5'b001, 1'b0);
        idle(3);
        chk("pre_rst_f", 0, 32'(fo[0]), 32'd1);

        // Reset with two samples in flight: neither may produce f_valid.
        n_before = hist_n[0];
        send(0, 5'b000, 1'b0);
        send(0, 5'b000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld = '0;
        chk("midrst_f", 0, 32'(fo[0]), 32'd0);
        chk("midrst_f_valid", 0, 32'(fvo[0]), 32'd0);
        chk("midrst_f_changed", 0, 32'(fco[0]), 32'd0);
`ifdef MINORITY_VOTER_STATS_EN
        chk("midrst_stats", 0, 32'(dco[0]), 32'd0);
`endif
        idle(4);
        chk("midrst_no_valid", 0, 32'(hist_n[0]), 32'(n_before));

        // N=5, HOLD=4, majority: settle mode, toggle on 4th, agreement resets, gaps.
        send(1, 5'b00000, 1'b1);
        for (int k = 0; k < 4; k++) send(1, 5'b00111, 1'b1);
        send(1, 5'b00001, 1'b1);
        send(1, 5'b00001, 1'b1);
        send(1, 5'b11111, 1'b1);
        for (int k = 0; k < 4; k++) send(1, 5'b00001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            send(1, 5'b00111, 1'b1);
            idle(5);
        end
        idle(3);
        chk("hold4_count", 1, 32'(hist_n[1]), 32'd16);
        chk("hold4_f", 1, 32'(hist_f[1][15:0]), 32'b1000_0111_1111_0000);
        chk("hold4_changed", 1, 32'(hist_c[1][15:0]), 32'b1000_1000_0001_0000);

        // N=3, HOLD=8: mode switch resyncs at once, including when a toggle is pending.
        send(2, 5'b011, 1'b0);
        send(2, 5'b111, 1'b1);
        for (int k = 0; k < 7; k++) send(2, 5'b000, 1'b1);
        send(2, 5'b011, 1'b0);
        send(2, 5'b011, 1'b0);
        idle(4);
        chk("hold8_count", 2, 32'(hist_n[2]), 32'd11);
        chk("hold8_f", 2, 32'(hist_f[2][10:0]), 32'b001_1111_1110);
        chk("hold8_changed", 2, 32'(hist_c[2][10:0]), 32'b010_0000_0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
